// File: rtl/iir_pkg.sv
// Shared IIR definitions: coefficient loader FSM states, bank size and the
// fixed slot order of the coefficient words (B0, B1, B2, B3, A1, A2).
package iir_pkg;

    localparam int NCOEF = 6;

    typedef logic [2:0] idx_t;

    localparam idx_t IDX_B0 = 3'd0;
    localparam idx_t IDX_B1 = 3'd1;
    localparam idx_t IDX_B2 = 3'd2;
    localparam idx_t IDX_B3 = 3'd3;
    localparam idx_t IDX_A1 = 3'd4;
    localparam idx_t IDX_A2 = 3'd5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } ld_state_t;

endpackage

// File: rtl/coef_loader_if.sv
// Load-word handshake between a coefficient source (master) and coef_loader
// (slave): valid/ready transfer plus an abort strobe.
interface coef_loader_if #(
    parameter int WIDTH = 14
) ();

    logic             LD_VLD;
    logic [WIDTH-1:0] LD_DATA;
    logic             LD_RDY;
    logic             LD_ABORT;

    modport master (output LD_VLD, output LD_DATA, output LD_ABORT, input  LD_RDY);
    modport slave  (input  LD_VLD, input  LD_DATA, input  LD_ABORT, output LD_RDY);

endinterface

// File: rtl/coef_bank.sv
// Shadow and active coefficient banks: words land in the shadow bank one slot
// at a time, and a commit copies the whole set to the active bank in one edge.
module coef_bank
    import iir_pkg::*;
#(
    parameter int WIDTH = 14
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en_i,
    input  idx_t                        wr_idx_i,
    input  logic [WIDTH-1:0]            wr_data_i,
    input  logic                        commit_i,
    output logic [NCOEF-1:0][WIDTH-1:0] active_o
`ifdef COEF_LOADER_CHKSUM_EN
    ,
    output logic [WIDTH-1:0]            shadow_sum_o
`endif
);

    logic [NCOEF-1:0][WIDTH-1:0] shadow_q;
    logic [NCOEF-1:0][WIDTH-1:0] active_q;

    // NOTE: both banks are reset explicitly; after reset the filter must see an
    // all-zero coefficient set, never power-up garbage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            for (int i = 0; i < NCOEF; i++) begin
                if (wr_en_i && (wr_idx_i == idx_t'(i))) begin
                    shadow_q[i] <= wr_data_i;
                end
            end
            if (commit_i) begin
                active_q <= shadow_q;
            end
        end
    end

    assign active_o = active_q;

`ifdef COEF_LOADER_CHKSUM_EN
    // Modulo-2^WIDTH sum; the carry out of each add is dropped on purpose.
    always_comb begin
        shadow_sum_o = '0;
        for (int i = 0; i < NCOEF; i++) begin
            shadow_sum_o = shadow_sum_o + shadow_q[i];
        end
    end
`endif

endmodule

// File: rtl/coef_loader.sv
// IIR coefficient loader: shadow-loads six words, then swaps the active bank
// only on a VIN-idle edge. `define COEF_LOADER_CHKSUM_EN adds a checksum word.
module coef_loader
    import iir_pkg::*;
#(
    parameter int WIDTH = 14
) (
    input  logic             CLK,
    input  logic             RST_n,
    coef_loader_if.slave     ld,
    input  logic             VIN,
    output logic [WIDTH-1:0] B0,
    output logic [WIDTH-1:0] B1,
    output logic [WIDTH-1:0] B2,
    output logic [WIDTH-1:0] B3,
    output logic [WIDTH-1:0] A1,
    output logic [WIDTH-1:0] A2,
    output logic             COEF_VLD,
    output logic             BUSY,
    output logic             ERR
);

    ld_state_t state_q, state_d;
    idx_t      idx_q, idx_d;
    logic      rdy_en_q;
    logic      coef_vld_q, coef_vld_d;
    logic      ld_rdy;
    logic      accept;
    logic      wr_en;
    logic      commit;

    logic [NCOEF-1:0][WIDTH-1:0] active;

`ifdef COEF_LOADER_CHKSUM_EN
    logic             err_q, err_d;
    logic [WIDTH-1:0] shadow_sum;
`endif

    // rdy_en_q holds LD_RDY low through reset and the first edge after it.
    always_comb begin
        ld_rdy = rdy_en_q && ((state_q == IDLE) || (state_q == LOAD));
`ifdef COEF_LOADER_CHKSUM_EN
        if (rdy_en_q && (state_q == CHECK)) begin
            ld_rdy = 1'b1;
        end
`endif
    end

    assign ld.LD_RDY = ld_rdy;
    assign accept    = ld.LD_VLD && ld_rdy;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            rdy_en_q   <= 1'b0;
            coef_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rdy_en_q   <= 1'b1;
            coef_vld_q <= coef_vld_d;
        end
    end

`ifdef COEF_LOADER_CHKSUM_EN
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch can
        // leave one unassigned and infer a latch.
        state_d    = state_q;
        idx_d      = idx_q;
        coef_vld_d = coef_vld_q;
        wr_en      = 1'b0;
        commit     = 1'b0;
`ifdef COEF_LOADER_CHKSUM_EN
        err_d      = err_q;
`endif
        if (ld.LD_ABORT) begin
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        wr_en   = 1'b1;
                        idx_d   = idx_q + 3'd1;
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        wr_en = 1'b1;
                        if (idx_q == IDX_A2) begin
                            idx_d = '0;
`ifdef COEF_LOADER_CHKSUM_EN
                            state_d = CHECK;
`else
                            state_d = COMMIT;
`endif
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end
                end
                CHECK: begin
`ifdef COEF_LOADER_CHKSUM_EN
                    if (accept) begin
                        if (ld.LD_DATA == shadow_sum) begin
                            state_d = COMMIT;
                        end else begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end
`else
                    state_d = IDLE;
`endif
                end
                COMMIT: begin
                    // Swap only between samples so the filter never mixes sets.
                    if (!VIN) begin
                        commit     = 1'b1;
                        coef_vld_d = 1'b1;
                        state_d    = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    coef_bank #(
        .WIDTH (WIDTH)
    ) u_bank (
        .clk          (CLK),
        .rst_n        (RST_n),
        .wr_en_i      (wr_en),
        .wr_idx_i     (idx_q),
        .wr_data_i    (ld.LD_DATA),
        .commit_i     (commit),
        .active_o     (active)
`ifdef COEF_LOADER_CHKSUM_EN
        ,
        .shadow_sum_o (shadow_sum)
`endif
    );

    assign B0       = active[IDX_B0];
    assign B1       = active[IDX_B1];
    assign B2       = active[IDX_B2];
    assign B3       = active[IDX_B3];
    assign A1       = active[IDX_A1];
    assign A2       = active[IDX_A2];
    assign COEF_VLD = coef_vld_q;
    assign BUSY     = (state_q != IDLE);

`ifdef COEF_LOADER_CHKSUM_EN
    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

endmodule
